// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the MangoMIPS32 stage registers and pipe_ctrl.
// master: pipeline side (raises requests, consumes stall/flush); slave: pipe_ctrl.
interface pipe_ctrl_if;
  logic        if_req;
  logic        mc_start;
  logic        mem_req;
  logic        exc_valid;
  logic [31:0] exc_vec;
  logic        eret;
  logic [31:0] epc;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        redirect;
  logic [31:0] redir_pc;
  logic        mc_last;
  logic [31:0] stall_cycles;

  modport master (
    output if_req, mc_start, mem_req, exc_valid, exc_vec, eret, epc,
    input  stall, flush, redirect, redir_pc, mc_last, stall_cycles
  );

  modport slave (
    input  if_req, mc_start, mem_req, exc_valid, exc_vec, eret, epc,
    output stall, flush, redirect, redir_pc, mc_last, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: multi-cycle EX counter and deferred PC redirect.
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MC_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int            CW       = $clog2(MC_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_LAT - 1);

  typedef enum logic [1:0] {
    RUN,
    MC,
    REDIR
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   tgt_q;

  logic          evt;
  logic [31:0]   tgt_new;
  logic          at_last;
  logic          mc_hold;

  assign evt     = bus.exc_valid | bus.eret;
  assign tgt_new = bus.exc_valid ? bus.exc_vec : bus.epc;
  assign at_last = (state_q == MC) && (cnt_q == CNT_LAST);
  // The start cycle is already a hold cycle, before the state register has moved to MC.
  assign mc_hold = ((state_q == RUN) && bus.mc_start) || ((state_q == MC) && !at_last);

  // NOTE: every output gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    bus.stall    = '0;
    bus.flush    = '0;
    bus.redirect = 1'b0;
    bus.redir_pc = tgt_q;
    bus.mc_last  = 1'b0;
    if (!rst) begin
      bus.mc_last = at_last && !evt;
      if (evt) begin
        bus.flush    = 5'b11110;
        bus.redir_pc = tgt_new;
        bus.redirect = !bus.if_req;
      end else if (bus.mem_req) begin
        bus.stall = 5'b01111;
        bus.flush = 5'b10000;
      end else if (state_q == REDIR) begin
        bus.flush = 5'b00010;
        if (bus.if_req) bus.stall    = 5'b00001;
        else            bus.redirect = 1'b1;
      end else if (mc_hold) begin
        bus.stall = 5'b00111;
        bus.flush = 5'b01000;
      end else if (bus.if_req) begin
        bus.stall = 5'b00001;
        bus.flush = 5'b00010;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else if (evt) begin
      tgt_q   <= tgt_new;
      cnt_q   <= '0;
      state_q <= bus.if_req ? REDIR : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.mc_start) begin
            state_q <= MC;
            cnt_q   <= CW'(1);
          end
        end
        MC: begin
          // Counter saturates on the last cycle; a D-cache miss keeps us parked there.
          if (!at_last) cnt_q <= cnt_q + CW'(1);
          if (at_last && !bus.mem_req) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        REDIR: begin
          if (!bus.if_req && !bus.mem_req) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  assign stall_cycles_d = stall_cycles_q + 32'(bus.stall[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MC_LAT=4); outputs compared as {stall, flush, redirect, mc_last}.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MC_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Input codes: {if_req, mc_start, mem_req, exc_valid, eret}
  localparam logic [4:0] I_NONE   = 5'b00000;
  localparam logic [4:0] I_IF     = 5'b10000;
  localparam logic [4:0] I_MC     = 5'b01000;
  localparam logic [4:0] I_MCM    = 5'b01100;
  localparam logic [4:0] I_MCEXC  = 5'b01010;
  localparam logic [4:0] I_EXC    = 5'b00010;
  localparam logic [4:0] I_EXCALL = 5'b00111;
  localparam logic [4:0] I_ER_IF  = 5'b10001;
  localparam logic [4:0] I_EXC_IF = 5'b10010;

  // Output codes: {stall, flush, redirect, mc_last}
  localparam logic [11:0] O_IDLE  = 12'b0;
  localparam logic [11:0] O_MCH   = {5'b00111, 5'b01000, 2'b00};
  localparam logic [11:0] O_MEM   = {5'b01111, 5'b10000, 2'b00};
  localparam logic [11:0] O_MEM_L = {5'b01111, 5'b10000, 2'b01};
  localparam logic [11:0] O_LAST  = {5'b00000, 5'b00000, 2'b01};
  localparam logic [11:0] O_FL_R  = {5'b00000, 5'b11110, 2'b10};
  localparam logic [11:0] O_FL    = {5'b00000, 5'b11110, 2'b00};
  localparam logic [11:0] O_IFH   = {5'b00001, 5'b00010, 2'b00};
  localparam logic [11:0] O_RD    = {5'b00000, 5'b00010, 2'b10};

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic logic [11:0] obs();
    return {bus.stall, bus.flush, bus.redirect, bus.mc_last};
  endfunction

  task automatic apply(input logic [4:0] v);
    {bus.if_req, bus.mc_start, bus.mem_req, bus.exc_valid, bus.eret} = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(5'b11111);
    bus.exc_vec = 32'hBFC0_0380;
    bus.epc     = 32'h8000_1234;
    #1;
    n_vec++;
    if (obs() !== O_IDLE) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", obs(), O_IDLE);
    end
    n_vec++;
    if (bus.redir_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_redir_pc: got %h want %h", bus.redir_pc, 32'h0);
    end
    n_vec++;
    if (bus.stall_cycles !== 32'h0) begin
      n_err++;
      $display("FAIL reset_stall_cycles: got %0d want 0", bus.stall_cycles);
    end
    @(negedge clk);
    apply(I_NONE);
    rst = 1'b0;
  endtask

  task automatic test_mc();
    logic [4:0]  in  [5];
    logic [11:0] exp [5];
    in  = '{I_MC, I_MC, I_MC, I_MC, I_NONE};
    exp = '{O_MCH, O_MCH, O_MCH, O_LAST, O_IDLE};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply(in[i]);
      #1;
      n_vec++;
      if (obs() !== exp[i]) begin
        n_err++;
        $display("FAIL mc_seq cyc%0d: got %b want %b", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_mc_mem();
    logic [4:0]  in  [7];
    logic [11:0] exp [7];
    in  = '{I_MC, I_MC, I_MC, I_MCM, I_MCM, I_MC, I_NONE};
    exp = '{O_MCH, O_MCH, O_MCH, O_MEM_L, O_MEM_L, O_LAST, O_IDLE};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      apply(in[i]);
      #1;
      n_vec++;
      if (obs() !== exp[i]) begin
        n_err++;
        $display("FAIL mc_mem cyc%0d: got %b want %b", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_mc_start_with_mem();
    logic [4:0]  in  [5];
    logic [11:0] exp [5];
    in  = '{I_MCM, I_MC, I_MC, I_MC, I_NONE};
    exp = '{O_MEM, O_MCH, O_MCH, O_LAST, O_IDLE};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply(in[i]);
      #1;
      n_vec++;
      if (obs() !== exp[i]) begin
        n_err++;
        $display("FAIL mc_start_mem cyc%0d: got %b want %b", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_exception();
    logic [4:0]  in  [3];
    logic [11:0] exp [3];
    logic [31:0] vec [3];
    logic [31:0] pc  [3];
    in  = '{I_EXC, I_EXCALL, I_NONE};
    exp = '{O_FL_R, O_FL_R, O_IDLE};
    vec = '{32'hBFC0_0380, 32'hBFC0_0200, 32'h0};
    pc  = '{32'hBFC0_0380, 32'hBFC0_0200, 32'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(in[i]);
      bus.exc_vec = vec[i];
      bus.epc     = 32'h1111_1110;
      #1;
      n_vec++;
      if (obs() !== exp[i]) begin
        n_err++;
        $display("FAIL exception cyc%0d: got %b want %b", i, obs(), exp[i]);
      end
      if (pc[i] != 32'h0) begin
        n_vec++;
        if (bus.redir_pc !== pc[i]) begin
          n_err++;
          $display("FAIL exception_pc cyc%0d: got %h want %h", i, bus.redir_pc, pc[i]);
        end
      end
    end
  endtask

  task automatic test_eret_redirect();
    logic [4:0]  in  [10];
    logic [11:0] exp [10];
    logic [31:0] epc [10];
    logic [31:0] vec [10];
    logic [31:0] pc  [10];
    // First: ERET while I-side busy for 3 more cycles; then a new exception overwrites a pending ERET.
    in  = '{I_ER_IF, I_IF, I_IF, I_IF, I_NONE, I_NONE, I_ER_IF, I_EXC_IF, I_IF, I_NONE};
    exp = '{O_FL, O_IFH, O_IFH, O_IFH, O_RD, O_IDLE, O_FL, O_FL, O_IFH, O_RD};
    epc = '{32'h8000_1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h8000_2000, 32'h0, 32'h0, 32'h0};
    vec = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h0, 32'h8000_0180, 32'h0, 32'h0};
    pc  = '{32'h8000_1234, 32'h8000_1234, 32'h8000_1234, 32'h8000_1234, 32'h8000_1234, 32'h0,
            32'h8000_2000, 32'h8000_0180, 32'h8000_0180, 32'h8000_0180};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply(in[i]);
      bus.epc     = epc[i];
      bus.exc_vec = vec[i];
      #1;
      n_vec++;
      if (obs() !== exp[i]) begin
        n_err++;
        $display("FAIL eret_redir cyc%0d: got %b want %b", i, obs(), exp[i]);
      end
      if (pc[i] != 32'h0) begin
        n_vec++;
        if (bus.redir_pc !== pc[i]) begin
          n_err++;
          $display("FAIL eret_redir_pc cyc%0d: got %h want %h", i, bus.redir_pc, pc[i]);
        end
      end
    end
  endtask

  task automatic test_exc_mid_mc();
    logic [4:0]  in  [8];
    logic [11:0] exp [8];
    in  = '{I_MC, I_MC, I_MCEXC, I_MC, I_MC, I_MC, I_MC, I_NONE};
    exp = '{O_MCH, O_MCH, O_FL_R, O_MCH, O_MCH, O_MCH, O_LAST, O_IDLE};
    bus.exc_vec = 32'hBFC0_0380;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apply(in[i]);
      #1;
      n_vec++;
      if (obs() !== exp[i]) begin
        n_err++;
        $display("FAIL exc_mid_mc cyc%0d: got %b want %b", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset two cycles into a multi-cycle op
    @(negedge clk); apply(I_MC);
    @(negedge clk); apply(I_MC);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs() !== O_IDLE) begin
      n_err++;
      $display("FAIL reset_mid_mc_hold: got %b want %b", obs(), O_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(I_NONE);
    #1;
    n_vec++;
    if (obs() !== O_IDLE) begin
      n_err++;
      $display("FAIL reset_mid_mc_after: got %b want %b", obs(), O_IDLE);
    end
    // Reset while a redirect is pending
    @(negedge clk);
    apply(I_ER_IF);
    bus.epc = 32'h8000_4444;
    @(negedge clk);
    apply(I_IF);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({obs(), bus.redir_pc} !== {O_IDLE, 32'h0}) begin
      n_err++;
      $display("FAIL reset_mid_redir_hold: got %b/%h want %b/%h", obs(), bus.redir_pc, O_IDLE, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(I_NONE);
    #1;
    n_vec++;
    if (obs() !== O_IDLE) begin
      n_err++;
      $display("FAIL reset_mid_redir_after: got %b want %b", obs(), O_IDLE);
    end
  endtask

  task automatic test_perf();
    @(negedge clk);
    apply(I_NONE);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      apply(I_IF);
      #1;
      n_vec++;
      if ({obs(), bus.stall_cycles} !== {O_IFH, (PERF ? 32'(i) : 32'h0)}) begin
        n_err++;
        $display("FAIL perf_count cyc%0d: got %b/%0d want %b/%0d", i, obs(), bus.stall_cycles,
                 O_IFH, (PERF ? i : 0));
      end
    end
    @(negedge clk);
    apply(I_NONE);
    #1;
    n_vec++;
    if (bus.stall_cycles !== (PERF ? 32'd7 : 32'd0)) begin
      n_err++;
      $display("FAIL perf_total: got %0d want %0d", bus.stall_cycles, (PERF ? 7 : 0));
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.stall_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL perf_after_reset: got %0d want 0", bus.stall_cycles);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mc();
    test_mc_mem();
    test_mc_start_with_mem();
    test_exception();
    test_eret_redirect();
    test_exc_mid_mc();
    test_reset_mid();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the MangoMIPS32 five-stage pipeline. It collects hold requests from IF (I-cache miss), EX (multi-cycle op) and MEM (D-cache miss) plus exception/ERET events from MEM. It drives the per-register `stall`/`flush` pair consumed by the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It owns the multi-cycle EX latency counter and a deferred PC-redirect state, so redirects are never lost while the I-side is busy.

## Interface
- `MC_LAT`, default 4: total EX cycles of a multi-cycle op, counting the start cycle; legal range 2..16.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  IF hold request (I-cache miss).
- `mc_start`  in  1  instruction in EX is multi-cycle (mul/div).
- `mem_req`  in  1  MEM hold request (D-cache miss).
- `exc_valid`  in  1  exception taken by the instruction in MEM.
- `exc_vec`  in  32  handler address.
- `eret`  in  1  ERET in MEM.
- `epc`  in  32  return address for ERET.
- `stall`  out  5  hold enables; bit 0 PC, 1 IF_ID, 2 ID_EX, 3 EX_MEM, 4 MEM_WB.
- `flush`  out  5  bubble enables, same bit order; bit 0 is always 0.
- `redirect`  out  1  PC must load `redir_pc` this cycle.
- `redir_pc`  out  32  redirect target.
- `mc_last`  out  1  final cycle of a multi-cycle op; the EX result is valid.
- `stall_cycles`  out  32  count of cycles with `stall[0]` high (see Configuration).

## Operation
- States: RUN, MC (multi-cycle busy), REDIR (redirect pending). Reset: RUN, counter 0, pending target 0, `stall_cycles` 0.
- `stall`/`flush`/`redirect`/`redir_pc`/`mc_last` are combinational from the state and inputs. All are 0 while `rst` is high.
- Request priority: exc_valid > eret > mem_req > MC hold > if_req.
- Exception or ERET, in any state:
  - `flush[4:1]`=4'b1111 and `stall`=0.
  - Target is `exc_vec` (exception) or `epc` (ERET); the target is latched.
  - MC counter cleared.
  - If `if_req`=0: `redirect`=1 that cycle and next state is RUN. Otherwise next state is REDIR.
- REDIR:
  - `redir_pc`=latched target, `stall[0]`=1, `flush[1]`=1.
  - When `if_req` falls: `redirect`=1 that cycle, `stall[0]`=0, next state RUN.
  - A new exception or ERET overwrites the latched target.
- `mem_req` (no exception/ERET): `stall[3:0]`=4'b1111, `flush[4]`=1.
- MC hold, i.e. state MC and not last: `stall[2:0]`=3'b111, `flush[3]`=1.
- `if_req` only: `stall[0]`=1, `flush[1]`=1.
- Invariant: `stall[k]` implies `stall[j]` for all j<k. A register never has `stall` and `flush` both high.
- MC sequencing:
  - In RUN, `mc_start`=1 and no higher-priority event: enter MC with counter=1.
  - In MC: counter increments each cycle until it reaches MC_LAT-1, then saturates.
  - `mc_last`=1 when counter==MC_LAT-1. While `mc_last`=1, MC hold is released.
  - In MC, exit to RUN on the cycle `mc_last`=1 with `mem_req`=0.
  - `mc_start` is ignored while in MC; the frozen instruction still presents it.
  - `mem_req` during MC: the counter keeps advancing and saturates. The state stays MC until `mem_req`=0.
- Counter width: `$clog2(MC_LAT)`.

## Timing
- Multi-cycle op, `mc_start` first seen at cycle t, no other requests:
  - EX held for cycles t..t+MC_LAT-2.
  - `mc_last` high at t+MC_LAT-1.
  - EX_MEM captures at the end of t+MC_LAT-1.
- Exception: flush and redirect occur in the same cycle as `exc_valid`. The handler fetch starts the next cycle.
- Redirect latency while `if_req`=1: redirect fires exactly on the first cycle `if_req`=0.
- Reset mid-MC or mid-REDIR: return to RUN immediately, dropping the pending target and counter.
- Simultaneous `mc_start` and `mem_req` in RUN: enter MC; the `mem_req` pattern dominates the outputs.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cycles` increments on every cycle with `stall[0]`=1, wraps at 2^32, and is cleared by `rst`.
- `PIPE_CTRL_PERF_EN` undefined: no counter is built and `stall_cycles` is tied to 0.

## Test plan
- MC_LAT=4, pulse `mc_start` high for 4 cycles from t0 -> `stall`=5'b00111 and `flush`=5'b01000 at t0..t0+2; `mc_last`=1 and `stall`=0 at t0+3; state RUN at t0+4.
- `mem_req` high at t0..t0+1 during MC cycle 2 -> `stall`=5'b01111, `flush`=5'b10000. `mc_last` holds at 1 until `mem_req` falls; EX_MEM captures on the first cycle `mem_req`=0.
- `exc_valid`=1 with `exc_vec`=0xBFC00380 and `if_req`=0 -> same cycle `flush`=5'b11110, `redirect`=1, `redir_pc`=0xBFC00380.
- `eret` with `epc`=0x80001234 while `if_req`=1 for 3 cycles -> REDIR; `stall[0]`=1 for 3 cycles, then `redirect`=1 with 0x80001234 on the cycle `if_req` falls.
- `exc_valid` at MC cycle 2 -> counter cleared, `mc_last` never asserts, and `mc_start` on the next RUN cycle restarts the full MC_LAT sequence.
- `PIPE_CTRL_PERF_EN` defined; 7 `if_req` cycles, then `rst` -> `stall_cycles`=7, then 0 after reset. Without the macro, `stall_cycles` reads 0 throughout.
